// File: rtl/change_monitor.sv
// Change monitor: timestamps value changes on two watched buses and queues
// them in a show-ahead event FIFO with sticky overflow and drop counting.
module change_monitor #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] sig_a,
  input  logic [WIDTH-1:0] sig_b,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [1:0]       ev_mask,
  output logic [TS_W-1:0]  ev_time,
  output logic [WIDTH-1:0] ev_a,
  output logic [WIDTH-1:0] ev_b,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [7:0]       drop_cnt
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = 2 + TS_W + 2 * WIDTH;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [TS_W-1:0]  ts_q;
  logic             base_pend_q;
  logic [WIDTH-1:0] last_a_q, last_b_q;
  logic             ovf_q;
  logic [7:0]       drop_cnt_q;

  logic [1:0]       mask_d;
  logic             sample_d, push_d, pop_d, full_d, drop_d, wr_en_d;
  logic             ovf_d;
  logic [7:0]       drop_cnt_d;
  logic [ENT_W-1:0] head_d;

  always_comb begin
    mask_d   = {sig_b != last_b_q, sig_a != last_a_q};
    sample_d = en & ~base_pend_q;
    push_d   = sample_d & (|mask_d);
    pop_d    = ev_ready & (count_q != '0);
    full_d   = (count_q == DEPTH_C);
    // A pop frees the head slot on the same edge, so a full FIFO can still accept.
    drop_d   = push_d & full_d & ~pop_d;
    wr_en_d  = push_d & ~drop_d;
  end

  always_comb begin
    ovf_d      = ovf_clr ? 1'b0 : ovf_q;
    drop_cnt_d = ovf_clr ? 8'd0 : drop_cnt_q;
    if (drop_d) begin
      ovf_d = 1'b1;
      if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q        <= '0;
      base_pend_q <= 1'b1;
      last_a_q    <= '0;
      last_b_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      ts_q       <= ts_q + 1'b1;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      if (en) begin
        base_pend_q <= 1'b0;
        last_a_q    <= sig_a;
        last_b_q    <= sig_b;
      end
      if (wr_en_d) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_d)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en_d, pop_d})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en_d) mem_q[wr_ptr_q] <= {mask_d, ts_q, sig_a, sig_b};
  end

  assign head_d   = mem_q[rd_ptr_q];
  assign ev_valid = (count_q != '0);
  assign ev_mask  = head_d[ENT_W-1 -: 2];
  assign ev_time  = head_d[2*WIDTH +: TS_W];
  assign ev_a     = head_d[WIDTH +: WIDTH];
  assign ev_b     = head_d[0 +: WIDTH];
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/change_monitor.md
CHANGE_MONITOR -- requirements
Module: change_monitor

Interface
REQ-001 Parameter WIDTH, default 32, width of each watched bus.
REQ-002 Parameter DEPTH, default 8, event FIFO entries; SHALL be a power of 2, at least 2.
REQ-003 Parameter TS_W, default 16, timestamp counter width.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port en  input  1  sampling enable.
REQ-007 Port sig_a  input  WIDTH  watched bus A.
REQ-008 Port sig_b  input  WIDTH  watched bus B.
REQ-009 Port ev_valid  output  1  event available at FIFO head.
REQ-010 Port ev_ready  input  1  consumer accepts head event.
REQ-011 Port ev_mask  output  2  head event change mask: bit0 = A changed, bit1 = B changed.
REQ-012 Port ev_time  output  TS_W  head event timestamp.
REQ-013 Port ev_a  output  WIDTH  head event value of sig_a.
REQ-014 Port ev_b  output  WIDTH  head event value of sig_b.
REQ-015 Port ovf  output  1  sticky overflow flag.
REQ-016 Port ovf_clr  input  1  clears ovf and drop_cnt.
REQ-017 Port drop_cnt  output  8  count of dropped events, saturating.

Function
REQ-018 Timestamp counter ts SHALL increment by 1 every cycle after reset, regardless of en, and wrap from 2^TS_W-1 to 0.
REQ-019 Baseline: on the first en=1 edge after reset, sig_a/sig_b SHALL load into last_a/last_b with no event generated.
REQ-020 On each later en=1 edge, mask = {sig_b!=last_b, sig_a!=last_a}; last_a/last_b SHALL update to the sampled values.
REQ-021 If mask is nonzero, one entry {mask, ts, sig_a, sig_b} SHALL be pushed; A and B changing on the same edge yield one entry with mask=2'b11.
REQ-022 With en=0, no sampling or push; last_a/last_b hold, and the next en=1 edge compares against the held values.
REQ-023 Latency: an event pushed at edge N into an empty FIFO SHALL show ev_valid=1 from after edge N.
REQ-024 The FIFO is show-ahead: ev_mask/ev_time/ev_a/ev_b reflect the head whenever ev_valid=1 and are don't-care otherwise.
REQ-025 Pop occurs on an edge with ev_valid=1 and ev_ready=1; ev_ready with ev_valid=0 has no effect.
REQ-026 ev_valid, once high, SHALL stay high with the head stable until popped.
REQ-027 Push and pop on the same edge SHALL both take effect, including when the FIFO is full.
REQ-028 Push when full without a same-edge pop SHALL drop the new event, set ovf, and increment drop_cnt, saturating at 255; FIFO contents are unchanged.
REQ-029 ovf_clr SHALL clear ovf and drop_cnt to 0; if a drop occurs on the same edge, ovf=1 and drop_cnt=1.
REQ-030 Events SHALL pop in push order; pointer wrap SHALL not lose or duplicate entries.

Reset
REQ-031 rst=1 SHALL set ts=0, FIFO empty, ev_valid=0, ovf=0, drop_cnt=0, and the baseline-pending state; last_a and last_b become don't-care.
REQ-032 rst overrides all inputs on the same edge; reset mid-stream discards queued events.

Verification
REQ-033 Reset, en=1, sig_a=0, sig_b=0 held -> ev_valid stays 0, ts counts 0,1,2,...
REQ-034 After baseline, set sig_a=5 at ts=10 -> next cycle ev_valid=1, ev_mask=01, ev_time=10, ev_a=5; ev_ready=1 pops -> ev_valid=0.
REQ-035 Change sig_a=1 and sig_b=1 on the same edge -> a single entry with ev_mask=11.
REQ-036 ev_ready=0, toggle sig_a on 10 consecutive edges with DEPTH=8 -> 8 entries held, ovf=1, drop_cnt=2; drain returns the first 8 in order.
REQ-037 FIFO full, change plus ev_ready=1 on the same edge -> no drop, count stays 8, ovf unchanged.
REQ-038 en=0 while sig_a changes 3->7, then en=1 -> one event with ev_a=7; assert rst with 4 queued -> ev_valid=0 next cycle.
